// File: rtl/fifo_burst_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_burst_drain                                                |
// | Purpose  : Drains the prefetch FIFO into fixed-length AXI-style write       |
// |            bursts, FRAME_BURSTS bursts per frame from a latched base.       |
// | Option   : FIFO_BURST_DRAIN_ERR_ABORT_EN - end the frame on a bad bresp.   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fifo_burst_drain #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 28,
    parameter int BURST_LEN    = 16,
    parameter int FRAME_BURSTS = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_vld,
    output logic                  fifo_rd_en,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_addr = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    localparam logic [7:0]            c_last_beat   = 8'(BURST_LEN - 1);
    localparam logic [15:0]           c_last_burst  = 16'(FRAME_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_burst_bytes = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [15:0]           burst_cnt_q, burst_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  bready_q, bready_d;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_bad_resp;
    logic w_frame_end;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= c_st_idle;
            awaddr_q    <= '0;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bready_q    <= bready_d;
        end
    end

    assign w_aw_hs    = (state_q == c_st_addr) && awready;
    assign w_w_hs     = (state_q == c_st_data) && fifo_rd_vld && wready;
    assign w_b_hs     = bready_q && bvalid;
    assign w_bad_resp = (bresp != 2'b00);
`ifdef FIFO_BURST_DRAIN_ERR_ABORT_EN
    assign w_frame_end = (burst_cnt_q == c_last_burst) || w_bad_resp;
`else
    assign w_frame_end = (burst_cnt_q == c_last_burst);
`endif

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        beat_cnt_d  = beat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        bready_d    = bready_q;
        case (state_q)
            c_st_idle: begin
                // The done cycle is already IDLE; a start coincident with it is dropped.
                if (start && !done_q) begin
                    awaddr_d    = base_addr;
                    err_d       = 1'b0;
                    burst_cnt_d = '0;
                    busy_d      = 1'b1;
                    state_d     = c_st_addr;
                end
            end
            c_st_addr: begin
                if (w_aw_hs) begin
                    beat_cnt_d = '0;
                    state_d    = c_st_data;
                end
            end
            c_st_data: begin
                if (w_w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == c_last_beat) begin
                        bready_d = 1'b1;
                        state_d  = c_st_resp;
                    end
                end
            end
            c_st_resp: begin
                if (w_b_hs) begin
                    bready_d = 1'b0;
                    if (w_bad_resp) begin
                        err_d = 1'b1;
                    end
                    if (w_frame_end) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = c_st_idle;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        awaddr_d    = awaddr_q + c_burst_bytes;
                        state_d     = c_st_addr;
                    end
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        awvalid    = (state_q == c_st_addr);
        wvalid     = (state_q == c_st_data) && fifo_rd_vld;
        fifo_rd_en = (state_q == c_st_data) && wready;
        wlast      = (state_q == c_st_data) && (beat_cnt_q == c_last_beat);
        wdata      = fifo_rd_data;
        awaddr     = awaddr_q;
        awlen      = c_last_beat;
        bready     = bready_q;
        busy       = busy_q;
        done       = done_q;
        err        = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fifo_burst_drain                                             |
// | Purpose  : Randomised scoreboard bench for fifo_burst_drain.               |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fifo_burst_drain;

    localparam int DW    = 32;
    localparam int AW    = 28;
    localparam int BL    = 16;
    localparam int FB    = 4;
    localparam int BYTES = BL * DW / 8;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_vld = 1'b0;
    logic          fifo_rd_en;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready = 1'b0;
    logic          wlast;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [1:0]    bresp = 2'b00;
    logic          busy;
    logic          done;
    logic          err;

    fifo_burst_drain #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .FRAME_BURSTS(FB)
    ) u_dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .base_addr(base_addr),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .busy(busy), .done(done), .err(err)
    );

    always #5 rd_clk = ~rd_clk;

    // Upstream FIFO contents: a fixed random stream indexed by pop count.
    logic [DW-1:0] fifo_mem [0:4095];
    int            fifo_seq = 0;
    assign fifo_rd_data = fifo_mem[fifo_seq % 4096];

    // Stimulus knobs (written by the main process only).
    bit fast     = 1'b1;
    int vld_mode = 1;     // 0 random, 1 always valid
    int wr_mode  = 1;     // 0 random, 1 always ready, 2 toggle
    int stall_at = -1;
    int err_burst = -1;
    int w_base   = 0;
    int b_base   = 0;

    // Scoreboard.
    logic [AW-1:0] exp_aw [$];
    logic [DW:0]   exp_w  [$];
    bit            exp_done [$];
    logic [DW:0]   ew;

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    int done_cnt = 0;
    int b_cnt = 0;
    int b_pending = 0;
    int stall_cyc = 0;
    bit pop_seen = 1'b0;
    bit b_hs_seen = 1'b0;
    bit wlast_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: observes handshakes mid-cycle, pops expectations and compares.
    always @(negedge rd_clk) begin
        pop_seen   = 1'b0;
        b_hs_seen  = 1'b0;
        wlast_seen = 1'b0;
        if (!rd_rst) begin
            if (awvalid && awready) begin
                aw_cnt++;
                if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else begin
                    check("awaddr", awaddr, exp_aw.pop_front());
                    check("awlen", awlen, BL - 1);
                end
            end
            if (wvalid && wready) begin
                w_cnt++;
                if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                else begin
                    ew = exp_w.pop_front();
                    check("wdata", wdata, ew[DW-1:0]);
                    check("wlast", wlast, ew[DW]);
                end
                if (wlast) wlast_seen = 1'b1;
            end
            if (fifo_rd_en) begin
                check("rd_en_vs_wready", wready, 1'b1);
                check("wvalid_passthru", wvalid, fifo_rd_vld);
            end
            if ((fifo_rd_en && fifo_rd_vld) || (wvalid && wready))
                check("pop_eq_beat", fifo_rd_en && fifo_rd_vld, wvalid && wready);
            if (fifo_rd_en && fifo_rd_vld) pop_seen = 1'b1;
            if (bvalid && bready) b_hs_seen = 1'b1;
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) check("done_unexpected", 64'd1, 64'd0);
                else check("err_at_done", err, exp_done.pop_front());
                check("busy_at_done", busy, 1'b0);
            end
        end
    end

    // Driver: FIFO and slave behaviour, updated just after each rising edge.
    always @(posedge rd_clk) begin
        #1;
        if (rd_rst) begin
            b_pending = 0;
            bvalid    = 1'b0;
        end else begin
            if (pop_seen) fifo_seq++;
            if (wlast_seen) b_pending++;
            if (b_hs_seen) begin
                b_pending--;
                b_cnt++;
                bvalid = 1'b0;
            end
            if (stall_at >= 0 && (w_cnt - w_base) == stall_at && stall_cyc < 5) begin
                fifo_rd_vld = 1'b0;
                stall_cyc++;
            end else begin
                fifo_rd_vld = (vld_mode == 1) ? 1'b1 : ($urandom_range(0, 99) < 70);
            end
            case (wr_mode)
                1:       wready = 1'b1;
                2:       wready = ~wready;
                default: wready = ($urandom_range(0, 99) < 70);
            endcase
            awready = fast ? 1'b1 : ($urandom_range(0, 99) < 50);
            if (!bvalid && b_pending > 0 && (fast || $urandom_range(0, 99) < 50)) begin
                bvalid = 1'b1;
                bresp  = ((b_cnt - b_base) == err_burst) ? 2'b10 : 2'b00;
            end
        end
    end

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, awvalid, 1'b0);
        check({tag, "_wvalid"}, wvalid, 1'b0);
        check({tag, "_fifo_rd_en"}, fifo_rd_en, 1'b0);
        check({tag, "_wlast"}, wlast, 1'b0);
        check({tag, "_bready"}, bready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_awaddr"}, awaddr, 0);
    endtask

    // Reference model: expected AW addresses, W beats and final err of a frame.
    task automatic start_frame(input logic [AW-1:0] base, input int eb, output int n);
        int tmo = 0;
        while ((busy || done) && tmo < 2000) begin step(); tmo++; end
        if (tmo >= 2000) check("idle_timeout", 64'd0, 64'd1);
        err_burst = eb;
        n = FB;
`ifdef FIFO_BURST_DRAIN_ERR_ABORT_EN
        if (eb >= 0 && eb < FB) n = eb + 1;
`endif
        for (int i = 0; i < n; i++) exp_aw.push_back(AW'(32'(base) + i * BYTES));
        for (int k = 0; k < n * BL; k++)
            exp_w.push_back({(k % BL) == BL - 1, fifo_mem[(fifo_seq + k) % 4096]});
        exp_done.push_back(eb >= 0 && eb < FB);
        w_base    = w_cnt;
        b_base    = b_cnt;
        start     = 1'b1;
        base_addr = base;
        step();
        start     = 1'b0;
        base_addr = AW'($urandom);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input int eb, input bit poke);
        int n;
        int aw0, w0, d0;
        int tmo = 0;
        aw0 = aw_cnt;
        w0  = w_cnt;
        d0  = done_cnt;
        start_frame(base, eb, n);
        if (poke) begin
            repeat (3) step();
            start     = 1'b1;
            base_addr = AW'(28'h0123440);
            step();
            start = 1'b0;
            check("busy_held_on_restart", busy, 1'b1);
        end
        while (done_cnt == d0 && tmo < 5000) begin step(); tmo++; end
        if (tmo >= 5000) check("frame_timeout", 64'd0, 64'd1);
        check("aw_count", aw_cnt - aw0, n);
        check("w_count", w_cnt - w0, n * BL);
        check("aw_queue_empty", exp_aw.size(), 0);
        check("w_queue_empty", exp_w.size(), 0);
        check("err_after_frame", err, (eb >= 0 && eb < FB));
    endtask

    initial begin
        int n;
        int tmo;
        for (int i = 0; i < 4096; i++) fifo_mem[i] = $urandom;
        #1;
        check_reset_outputs("reset");
        repeat (3) step();
        rd_rst = 1'b0;
        step();
        check_reset_outputs("post_reset");

        // Nominal frame.
        run_frame(AW'(28'h100), -1, 1'b0);

        // FIFO empties for 5 cycles after 7 beats.
        stall_at = 7;
        run_frame(AW'(28'h400), -1, 1'b0);
        stall_at = -1;

        // Toggling wready.
        wr_mode = 2;
        run_frame(AW'(28'h800), -1, 1'b0);
        wr_mode = 1;

        // Slave error on the second burst.
        run_frame(AW'(28'h200), 1, 1'b0);

        // Start while busy plus address wrap.
        run_frame(AW'(28'hFFFFFC0), -1, 1'b1);

        // Asynchronous reset after 5 beats of the first burst.
        start_frame(AW'(28'h300), -1, n);
        tmo = 0;
        while ((w_cnt - w_base) < 5 && tmo < 1000) begin step(); tmo++; end
        if (tmo >= 1000) check("reset_wait_timeout", 64'd0, 64'd1);
        rd_rst = 1'b1;
        #1;
        check_reset_outputs("midburst_reset");
        exp_aw.delete();
        exp_w.delete();
        exp_done.delete();
        repeat (2) step();
        rd_rst = 1'b0;
        run_frame(AW'(28'h1000), -1, 1'b0);

        // Randomised frames.
        for (int f = 0; f < 4; f++) begin
            fast     = $urandom_range(0, 1);
            vld_mode = $urandom_range(0, 1);
            wr_mode  = $urandom_range(0, 2);
            run_frame(AW'($urandom) & ~AW'(63), int'($urandom_range(0, 5)) - 1, $urandom_range(0, 1));
        end

        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
